cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Coprocessor-0 exception and interrupt controller for the pipelined MIPS core. It sits at the M stage, which is the commit point. It consumes the exception codes produced upstream, including the instruction-fetch AdEL flagged by the PC register, and the external hardware interrupt lines. When an exception or interrupt is taken it raises a flush/redirect request and captures the victim PC into EPC. On `eret` it supplies EPC back to the fetch side. It also implements the architected SR, Cause, EPC and PRId registers for `mfc0`/`mtc0`.

## Interface
- `HANDLER_ADDR`, 32'h0000_4180, PC the fetch side loads when `Req`=1
- `PRID_VAL`, 32'h0000_2021, constant returned by PRId (reg 15)
- `clk` in 1 system clock, rising edge
- `reset` in 1 synchronous, active-high reset
- `A` in 5 CP0 register number for `mfc0` read and `mtc0` write
- `DIn` in 32 `mtc0` write data
- `WE` in 1 `mtc0` write enable (M-stage `mtc0` valid)
- `VPC` in 32 PC of the M-stage instruction
- `BDIn` in 1 M-stage instruction is in a branch delay slot
- `ExcCodeIn` in 5 pipelined exception code; 0 means none. AdEL=4, AdES=5, RI=10, Ov=12
- `HWInt` in 6 external interrupt lines, level-sensitive
- `EXLClr` in 1 M-stage `eret`
- `Req` out 1 take exception/interrupt this cycle (combinational)
- `DOut` out 32 `mfc0` read data (combinational on `A`)
- `EPCOut` out 32 current EPC register value
- `HandlerPC` out 32 equals `HANDLER_ADDR`

## Operation
- Registers and fields:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC (14): full 32 bits.
  - PRId (15): constant `PRID_VAL`.
- Request terms:
  - `IntReq` = |(`HWInt` & SR.IM) & SR.IE & !SR.EXL
  - `ExcReq` = (`ExcCodeIn`≠0) & !SR.EXL
  - `Req` = `IntReq` | `ExcReq`
- On a clock edge with `Req`=1:
  - SR.EXL←1.
  - Cause.ExcCode←0 if `IntReq`, else `ExcCodeIn`. Interrupt has priority over a simultaneous exception.
  - Cause.BD←`BDIn`.
  - EPC←`BDIn` ? `VPC`−4 : `VPC`. Arithmetic is 32-bit modulo 2^32, so 0x0000_0000−4 = 0xFFFF_FFFC. EPC is stored unaligned if `VPC` is unaligned; an AdEL on a misaligned PC keeps its raw address.
- Cause.IP←`HWInt` on every edge, independent of `Req`/EXL.
- On `EXLClr`=1 without `Req`: SR.EXL←0.
- `mtc0` (`WE`=1, `Req`=0):
  - A=12 writes IM, EXL, IE from the corresponding `DIn` bits.
  - A=14 writes EPC←`DIn`.
  - Writes to A=13, 15 or any other number are ignored.
- Priority per edge: `Req` > `EXLClr` > `WE`. When `Req`=1, `WE` and `EXLClr` are discarded in that cycle, because the instruction is being cancelled.
- `DOut`:
  - Selected register by `A`; 0 for unimplemented numbers.
  - Reads the pre-edge value; there is no write-to-read bypass.
- `EPCOut` is the registered EPC. The hazard unit stalls an `eret` in D while an `mtc0` to EPC is in E or M, so no bypass is required here.

## Timing
- Reset (sync, `reset`=1 at edge): SR=0, Cause=0, EPC=0.
- After reset:
  - `Req`=0, because IE=0 and `ExcCodeIn` is 0 from the flushed pipeline.
  - `DOut` reflects the zeroed registers.
  - `EPCOut`=0.
  - `HandlerPC`=`HANDLER_ADDR`.
- `reset` overrides `Req`, `WE` and `EXLClr` in the same cycle.
- `Req` is combinational within the cycle from M-stage inputs and current SR. The PC loads `HandlerPC` and the F/D/E/M registers are flushed at the same edge at which EXL is set.
- With EXL=1, `Req` stays 0 for all following cycles regardless of `HWInt`/`ExcCodeIn`. There is no nested exception. Re-arm only by `eret` or by `mtc0` SR.EXL=0.
- `HWInt` asserted for exactly one cycle while enabled is taken in that cycle. It is not latched, so a pulse during EXL=1 is lost except for its trace in Cause.IP.
- Back-to-back: `eret` at edge N clears EXL. A pending interrupt present in cycle N+1 raises `Req` in cycle N+1.

## Test plan
- Reset then read: `reset`=1 one edge, then `A`=12/13/14/15 → `DOut`=0, 0, 0, 0x00002021; `Req`=0.
- mtc0/mfc0 SR: `WE`=1, `A`=12, `DIn`=0xFFFF_FFFF → next cycle `DOut`(A=12)=0x0000_FC03. Then `WE`=1, `A`=13, `DIn`=0xFFFF_FFFF → Cause still 0.
- Exception in delay slot:
  - Setup: SR=0x0000_FC01, `ExcCodeIn`=12, `BDIn`=1, `VPC`=0x0000_3008.
  - Same cycle: `Req`=1.
  - After edge: EPC=0x0000_3004, Cause=0x8000_0030, SR.EXL=1.
  - Next cycle: `ExcCodeIn`=10 → `Req`=0.
- Interrupt beats exception and beats mtc0:
  - Setup: SR=0x0000_0401, `HWInt`=6'b000001, `ExcCodeIn`=4, `VPC`=0x0000_3001, `WE`=1, `A`=14, `DIn`=0x1234.
  - Result: `Req`=1, Cause.ExcCode=0, Cause.IP=0x01, EPC=0x0000_3001 (mtc0 dropped).
- Masked interrupt and eret:
  - With IM=0, `HWInt`=6'b111111 → `Req`=0, Cause=0x0000_FC00.
  - Take an exception, then pulse `EXLClr` with an enabled interrupt pending → EXL clears at edge N, and `Req`=1 in cycle N+1 with EPC updated to the new `VPC`.
- Reset mid-handler: EXL=1, EPC=0x3010, assert `reset` together with `WE`=1, `A`=12 → SR=0, EPC=0, `Req`=0.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt controller at the M (commit) stage.
// Decides whether to take a trap this cycle and holds SR, Cause, EPC and PRId.
module cp0_exc_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h0000_2021
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // EXL masks every new request: no nesting until eret or an mtc0 clears it.
    assign int_req = (|(HWInt & im)) & ie & ~exl;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
    assign Req     = int_req | exc_req;

    // Req cancels the M-stage instruction, so its eret/mtc0 side effects are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                bd       <= BDIn;
                epc      <= BDIn ? (VPC - 32'd4) : VPC;
            end else if (EXLClr) begin
                exl <= 1'b0;
            end else if (WE) begin
                if (A == REG_SR) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end else if (A == REG_EPC) begin
                    epc <= DIn;
                end
            end
        end
    end

    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    always_comb begin
        DOut = 32'd0;
        case (A)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

    assign EPCOut    = epc;
    assign HandlerPC = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios then random cycles, checked by a
// queue-based scoreboard fed from a word-level reference model.
module tb_cp0_exc_unit;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam logic [31:0] PRID    = 32'h0000_2021;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;

    cp0_exc_unit #(.HANDLER_ADDR(HANDLER), .PRID_VAL(PRID)) dut (
        .clk(clk), .reset(reset), .A(A), .DIn(DIn), .WE(WE), .VPC(VPC),
        .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .Req(Req), .DOut(DOut), .EPCOut(EPCOut), .HandlerPC(HandlerPC)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected entry: {Req, DOut, EPCOut, HandlerPC}
    logic [96:0] exp_q[$];

    // Reference model: architected registers as whole 32-bit words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; sample mid-cycle.
    always @(negedge clk) begin
        logic [96:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("req", {31'd0, Req}, {31'd0, e[96]});
            chk("dout", DOut, e[95:64]);
            chk("epcout", EPCOut, e[63:32]);
            chk("handler", HandlerPC, e[31:0]);
        end
    end

    // Driver: apply one cycle of inputs, predict the response, advance the model.
    task automatic cyc(input logic rst, input logic [4:0] a, input logic [31:0] din,
                       input logic we, input logic [31:0] vpc, input logic bd,
                       input logic [4:0] exc, input logic [5:0] hw, input logic eret);
        logic        ints, excs, rq;
        logic [31:0] dexp, sr_n, cause_n, epc_n;
        reset = rst; A = a; DIn = din; WE = we; VPC = vpc; BDIn = bd;
        ExcCodeIn = exc; HWInt = hw; EXLClr = eret;

        ints = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        excs = (exc != 5'd0) && !m_sr[1];
        rq   = ints || excs;
        case (a)
            5'd12:   dexp = m_sr;
            5'd13:   dexp = m_cause;
            5'd14:   dexp = m_epc;
            5'd15:   dexp = PRID;
            default: dexp = 32'd0;
        endcase
        if (m_valid) exp_q.push_back({rq, dexp, m_epc, HANDLER});

        sr_n    = m_sr;
        cause_n = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
        epc_n   = m_epc;
        if (rst) begin
            sr_n = 32'd0; cause_n = 32'd0; epc_n = 32'd0;
        end else if (rq) begin
            sr_n    = sr_n | 32'h2;
            cause_n = (cause_n & 32'h0000_FC00) | ({31'd0, bd} << 31)
                      | ({27'd0, (ints ? 5'd0 : exc)} << 2);
            epc_n   = bd ? vpc - 32'd4 : vpc;
        end else if (eret) begin
            sr_n = sr_n & ~32'h2;
        end else if (we && a == 5'd12) begin
            sr_n = din & 32'h0000_FC03;
        end else if (we && a == 5'd14) begin
            epc_n = din;
        end

        @(posedge clk);
        m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
        if (rst) m_valid = 1'b1;
        #1;
    endtask

    task automatic idle(input logic [4:0] a);
        cyc(1'b0, a, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] din);
        cyc(1'b0, a, din, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    endtask

    initial begin
        logic [4:0] ra;
        // Reset and read every implemented register.
        cyc(1'b1, 5'd12, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        chk("reset_epc", EPCOut, 32'd0);
        for (int r = 12; r <= 15; r++) idle(5'(r));
        chk("prid_read", DOut, PRID);

        // SR write masks to implemented fields; Cause is read-only.
        wr(5'd12, 32'hFFFF_FFFF);
        chk("sr_mask", DOut, 32'h0000_FC03);
        wr(5'd13, 32'hFFFF_FFFF);
        chk("cause_ro", DOut, 32'd0);

        // Overflow in a delay slot.
        wr(5'd12, 32'h0000_FC01);
        cyc(1'b0, 5'd14, 32'd0, 1'b0, 32'h0000_3008, 1'b1, 5'd12, 6'd0, 1'b0);
        chk("epc_delay_slot", EPCOut, 32'h0000_3004);
        cyc(1'b0, 5'd13, 32'd0, 1'b0, 32'h0000_300C, 1'b0, 5'd10, 6'd0, 1'b0);
        chk("cause_delay_slot", DOut, 32'h8000_0030);
        cyc(1'b0, 5'd12, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);

        // Interrupt beats an AdEL and the mtc0 to EPC in the same cycle.
        wr(5'd12, 32'h0000_0401);
        cyc(1'b0, 5'd14, 32'h0000_1234, 1'b1, 32'h0000_3001, 1'b0, 5'd4, 6'b000001, 1'b0);
        chk("epc_int_prio", EPCOut, 32'h0000_3001);
        idle(5'd13);
        chk("cause_int_prio", DOut, 32'h0000_0000);
        cyc(1'b0, 5'd12, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);

        // Masked interrupt lines only show up in Cause.IP.
        wr(5'd12, 32'h0000_0001);
        cyc(1'b0, 5'd13, 32'd0, 1'b0, 32'h0000_0100, 1'b0, 5'd0, 6'b111111, 1'b0);
        chk("cause_masked", DOut, 32'h0000_FC00);

        // eret followed immediately by a pending interrupt.
        wr(5'd12, 32'h0000_0401);
        cyc(1'b0, 5'd12, 32'd0, 1'b0, 32'h0000_0100, 1'b0, 5'd5, 6'd0, 1'b0);
        cyc(1'b0, 5'd12, 32'd0, 1'b0, 32'h0000_0104, 1'b0, 5'd0, 6'b000001, 1'b1);
        cyc(1'b0, 5'd12, 32'd0, 1'b0, 32'h0000_0200, 1'b0, 5'd0, 6'b000001, 1'b0);
        chk("epc_after_eret", EPCOut, 32'h0000_0200);

        // Reset in the middle of a handler wins over an mtc0.
        wr(5'd14, 32'h0000_3010);
        chk("epc_mtc0", EPCOut, 32'h0000_3010);
        cyc(1'b1, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h0000_0400, 1'b0, 5'd0, 6'd0, 1'b0);
        chk("epc_reset_mid", EPCOut, 32'd0);
        idle(5'd12);

        // EPC wraps modulo 2^32 for a delay-slot trap at address 0.
        cyc(1'b0, 5'd13, 32'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd4, 6'd0, 1'b0);
        chk("epc_wrap", EPCOut, 32'hFFFF_FFFC);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(5))
                0:       ra = 5'd12;
                1:       ra = 5'd13;
                2:       ra = 5'd14;
                3:       ra = 5'd15;
                4:       ra = 5'($urandom_range(31));
                default: ra = 5'd12;
            endcase
            cyc(($urandom_range(63) == 0), ra, $urandom, ($urandom_range(2) == 0),
                $urandom, 1'($urandom_range(1)),
                ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'd0,
                ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(63)),
                ($urandom_range(3) == 0));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
